// File: rtl/tick_debouncer.sv
// rtl/tick_debouncer.sv - tick-strobed push-button debouncer with press/release pulses
// Optional feature macro: TICK_DEBOUNCER_AUTO_REPEAT_EN (auto-repeat press pulses while held)
`timescale 1ns/1ps
module tick_debouncer #(
  parameter int STABLE_COUNT  = 4,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 10
) (
  input  logic clock_in,
  input  logic reset_n,
  input  logic sample_tick,
  input  logic button_in,
  output logic button_out,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int CW = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_COUNT);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic          r_sync_meta;
  logic          r_sync_q;
  state_t        r_state;
  state_t        w_state_nx;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;
  logic [CW-1:0] w_cnt_inc;
  logic          w_commit_rise;
  logic          w_commit_fall;
  logic          w_button_nx;
  logic          w_rep_fire;
  logic          r_button_out;
  logic          r_press;
  logic          r_release;

  // Two-flop synchroniser for the raw asynchronous button
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync_meta <= 1'b0;
      r_sync_q    <= 1'b0;
    end else begin
      r_sync_meta <= button_in;
      r_sync_q    <= r_sync_meta;
    end
  end

  // Counter is zero in both idle states, so the same increment serves the first sample
  assign w_cnt_inc = r_cnt + CW'(1);

  // Next-state logic: only sample ticks can move the FSM or the stable counter
  always_comb begin
    w_state_nx    = r_state;
    w_cnt_nx      = r_cnt;
    w_commit_rise = 1'b0;
    w_commit_fall = 1'b0;
    if (sample_tick) begin
      case (r_state)
        IDLE_LOW: begin
          if (r_sync_q) begin
            if (w_cnt_inc == STABLE_LAST) begin
              w_state_nx    = IDLE_HIGH;
              w_cnt_nx      = '0;
              w_commit_rise = 1'b1;
            end else begin
              w_state_nx = WAIT_HIGH;
              w_cnt_nx   = w_cnt_inc;
            end
          end
        end
        WAIT_HIGH: begin
          if (r_sync_q) begin
            if (w_cnt_inc == STABLE_LAST) begin
              w_state_nx    = IDLE_HIGH;
              w_cnt_nx      = '0;
              w_commit_rise = 1'b1;
            end else begin
              w_cnt_nx = w_cnt_inc;
            end
          end else begin
            w_state_nx = IDLE_LOW;
            w_cnt_nx   = '0;
          end
        end
        IDLE_HIGH: begin
          if (!r_sync_q) begin
            if (w_cnt_inc == STABLE_LAST) begin
              w_state_nx    = IDLE_LOW;
              w_cnt_nx      = '0;
              w_commit_fall = 1'b1;
            end else begin
              w_state_nx = WAIT_LOW;
              w_cnt_nx   = w_cnt_inc;
            end
          end
        end
        WAIT_LOW: begin
          if (!r_sync_q) begin
            if (w_cnt_inc == STABLE_LAST) begin
              w_state_nx    = IDLE_LOW;
              w_cnt_nx      = '0;
              w_commit_fall = 1'b1;
            end else begin
              w_cnt_nx = w_cnt_inc;
            end
          end else begin
            w_state_nx = IDLE_HIGH;
            w_cnt_nx   = '0;
          end
        end
        default: begin
          w_state_nx = IDLE_LOW;
          w_cnt_nx   = '0;
        end
      endcase
    end
  end

  // Debounced level is high whenever the committed level is high, including while a drop is pending
  assign w_button_nx = (w_state_nx == IDLE_HIGH) || (w_state_nx == WAIT_LOW);

`ifdef TICK_DEBOUNCER_AUTO_REPEAT_EN
  logic [7:0] r_rep_cnt;
  logic [7:0] w_rep_cnt_nx;
  logic [7:0] w_rep_cnt_inc;
  logic [7:0] w_rep_target;
  logic       r_rep_armed;
  logic       w_rep_armed_nx;

  assign w_rep_target  = r_rep_armed ? 8'(REPEAT_PERIOD) : 8'(REPEAT_DELAY);
  assign w_rep_cnt_inc = r_rep_cnt + 8'd1;

  // Repeat timer runs only while the button stays committed high and undisturbed
  always_comb begin
    w_rep_cnt_nx   = r_rep_cnt;
    w_rep_armed_nx = r_rep_armed;
    w_rep_fire     = 1'b0;
    if ((r_state != IDLE_HIGH) || (w_state_nx != IDLE_HIGH)) begin
      w_rep_cnt_nx   = '0;
      w_rep_armed_nx = 1'b0;
    end else if (sample_tick) begin
      if (w_rep_cnt_inc == w_rep_target) begin
        w_rep_fire     = 1'b1;
        w_rep_cnt_nx   = '0;
        w_rep_armed_nx = 1'b1;
      end else begin
        w_rep_cnt_nx = w_rep_cnt_inc;
      end
    end
  end

  // Repeat timer registers; after the first repeat the shorter period is used
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_rep_cnt   <= '0;
      r_rep_armed <= 1'b0;
    end else begin
      r_rep_cnt   <= w_rep_cnt_nx;
      r_rep_armed <= w_rep_armed_nx;
    end
  end
`else
  logic w_unused_repeat_cfg;

  assign w_rep_fire          = 1'b0;
  assign w_unused_repeat_cfg = ^{8'(REPEAT_DELAY), 8'(REPEAT_PERIOD)};
`endif

  // State, counter and registered outputs; pulses self-clear on the following cycle
  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE_LOW;
      r_cnt        <= '0;
      r_button_out <= 1'b0;
      r_press      <= 1'b0;
      r_release    <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_button_out <= w_button_nx;
      r_press      <= w_commit_rise | w_rep_fire;
      r_release    <= w_commit_fall;
    end
  end

  assign button_out    = r_button_out;
  assign press_pulse   = r_press;
  assign release_pulse = r_release;

endmodule

// File: tb/tb_tick_debouncer.sv
// tb/tb_tick_debouncer.sv - self-checking bench for tick_debouncer with a behavioural reference model
`timescale 1ns/1ps
module tb_tick_debouncer;

  localparam int SC = 4;
  localparam int RD = 5;
  localparam int RP = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick = 1'b0;
  logic btn = 1'b0;
  logic btn1 = 1'b0;
  logic out, press, rel;
  logic out1, press1, rel1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tick_debouncer #(.STABLE_COUNT(SC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut (
    .clock_in(clk), .reset_n(rst_n), .sample_tick(tick), .button_in(btn),
    .button_out(out), .press_pulse(press), .release_pulse(rel)
  );

  tick_debouncer #(.STABLE_COUNT(1)) u_dut1 (
    .clock_in(clk), .reset_n(rst_n), .sample_tick(1'b1), .button_in(btn1),
    .button_out(out1), .press_pulse(press1), .release_pulse(rel1)
  );

  // Reference model: committed level plus length of the current run of disagreeing samples
  bit hist[$];
  bit m_level, m_press, m_rel;
  int m_run, m_held;

  int phase = 0;
  int tick_mode = 0;
  int n_press = 0, n_rel = 0, n_tick = 0;

  task automatic model_reset();
    hist = {1'b0, 1'b0};
    m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0;
    m_run = 0; m_held = 0;
  endtask

  task automatic model_step();
    bit s;
    s = hist[0];
    void'(hist.pop_front());
    hist.push_back(btn);
    m_press = 1'b0;
    m_rel = 1'b0;
    if (tick) begin
      if (s != m_level) begin
        m_run++;
        m_held = 0;
        if (m_run == SC) begin
          m_level = s;
          m_run = 0;
          if (s) m_press = 1'b1; else m_rel = 1'b1;
        end
      end else begin
        if (m_level && m_run == 0) begin
          m_held++;
`ifdef TICK_DEBOUNCER_AUTO_REPEAT_EN
          if (m_held == RD || (m_held > RD && (m_held - RD) % RP == 0)) m_press = 1'b1;
`endif
        end
        m_run = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    if (tick_mode == 0) begin
      tick = (phase == 9);
      phase = (phase == 9) ? 0 : phase + 1;
    end else begin
      tick = ($urandom_range(0, 2) == 0);
    end
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    chk("button_out", out, m_level);
    chk("press_pulse", press, m_press);
    chk("release_pulse", rel, m_rel);
    chk("pulse_exclusive", press & rel, 1'b0);
    if (press) n_press++;
    if (rel) n_rel++;
    if (tick) n_tick++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic clr_counts();
    n_press = 0; n_rel = 0; n_tick = 0;
  endtask

  initial begin
    bit seen;
    model_reset();
    btn = 1'b1;
    btn1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out", out, 1'b0);
    chk("reset_press", press, 1'b0);
    chk("reset_rel", rel, 1'b0);
    chk("reset_out1", out1, 1'b0);

    btn = 1'b0;
    btn1 = 1'b0;
    rst_n = 1'b1;
    phase = 0;
    run(20);
    chk("no_pulse_after_reset", out | press | rel | press1 | rel1, 1'b0);

    // STABLE_COUNT=1 with tick tied high: 2 sync clocks + 1 commit clock
    btn1 = 1'b1;
    cyc(); chk("sc1_clk1", out1, 1'b0);
    cyc(); chk("sc1_clk2", out1, 1'b0);
    cyc(); chk("sc1_clk3", out1, 1'b1); chk("sc1_press", press1, 1'b1);
    cyc(); chk("sc1_press_once", press1, 1'b0);
    btn1 = 1'b0;
    cyc(); cyc(); cyc();
    chk("sc1_fall", out1, 1'b0); chk("sc1_release", rel1, 1'b1);
    cyc(); chk("sc1_release_once", rel1, 1'b0);

    // Clean press
    clr_counts();
    btn = 1'b1;
    run(60);
    chk("clean_out", out, 1'b1);
    chk_int("clean_press_cnt", n_press, 1);
    chk_int("clean_rel_cnt", n_rel, 0);

    // Release
    clr_counts();
    btn = 1'b0;
    run(60);
    chk("release_out", out, 1'b0);
    chk_int("release_rel_cnt", n_rel, 1);
    chk_int("release_press_cnt", n_press, 0);

    // Bounce then steady high
    clr_counts();
    btn = 1'b1; run(8);
    btn = 1'b0; run(8);
    btn = 1'b1; run(8);
    btn = 1'b0; run(8);
    chk_int("bounce_quiet", n_press, 0);
    chk("bounce_out_low", out, 1'b0);
    btn = 1'b1;
    run(60);
    chk_int("bounce_press_cnt", n_press, 1);
    chk("bounce_out_high", out, 1'b1);

    // Asynchronous reset while committed high clears outputs before any clock edge
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk("async_reset_out", out, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    btn = 1'b0;
    rst_n = 1'b1;
    phase = 0;
    run(30);

    // Held press: repeats only with the auto-repeat build
    btn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin cyc(); seen = press; end
    chk("hold_commit_seen", seen, 1'b1);
    clr_counts();
    run(120);
`ifdef TICK_DEBOUNCER_AUTO_REPEAT_EN
    chk_int("hold_repeat_cnt", n_press, 4);
`else
    chk_int("hold_repeat_cnt", n_press, 0);
`endif
    clr_counts();
    btn = 1'b0;
    run(80);
    chk_int("after_release_press_cnt", n_press, 0);
    chk_int("after_release_rel_cnt", n_rel, 1);

    // Reset in WAIT_HIGH at count 2: partial count discarded, 4 fresh ticks needed
    btn = 1'b1;
    for (int i = 0; i < 100 && m_run != 2; i++) cyc();
    chk_int("reached_wait_cnt2", m_run, 2);
    #2 rst_n = 1'b0;
    model_reset();
    #1 chk("midwait_reset_out", out, 1'b0);
    chk("midwait_reset_press", press, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    phase = 0;
    clr_counts();
    for (int i = 0; i < 200 && !out; i++) cyc();
    chk("midwait_recommit", out, 1'b1);
    chk_int("midwait_ticks", n_tick, 4);

    // Random ticks and button activity against the model
    tick_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) btn = ~btn;
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
